// File: rtl/tdc_pkg.sv
// Shared constants and state encoding for the TDC record writer.
// Record length depends on the optional TDC_SEQ_TAG_EN sequence-tag feature.
package tdc_pkg;

  localparam int unsigned TDC_DATA_W = 24;
  localparam int unsigned BYTE_W     = 8;
`ifdef TDC_SEQ_TAG_EN
  localparam int unsigned RECORD_BYTES = 4;
`else
  localparam int unsigned RECORD_BYTES = 3;
`endif
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/tdc_fifo_writer.sv
// Serialises a 24-bit TDC measurement into MSB-first bytes for a byte FIFO,
// aborting on FIFO stall timeout. Define TDC_SEQ_TAG_EN to prepend a sequence byte.
module tdc_fifo_writer
  import tdc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [TDC_DATA_W-1:0] tdc_data,
  input  logic                  fifo_full,
  output logic [BYTE_W-1:0]     fifo_din,
  output logic                  fifo_wr_en,
  output logic                  writing_done,
  output logic                  err,
  output logic                  busy,
  output logic [BYTE_W-1:0]     drop_cnt
);

  state_e                  state;
  logic                    wr_req_q;
  logic [TDC_DATA_W-1:0]   data_q;
  logic [IDX_W-1:0]        idx;
  logic [STALL_W-1:0]      stall_cnt;
  logic                    err_q;
  logic [BYTE_W-1:0]       drop_q;
  logic [BYTE_W-1:0]       byte_sel;
  logic                    req_edge;
  logic                    last_byte;
  logic                    stall_limit;
`ifdef TDC_SEQ_TAG_EN
  logic [BYTE_W-1:0]       seq_q;
`endif

  assign req_edge    = wr_req & ~wr_req_q;
  assign last_byte   = (idx == IDX_W'(RECORD_BYTES - 1));
  assign stall_limit = (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  // Byte selected by the current index, most significant byte first
  always_comb begin
    byte_sel = '0;
`ifdef TDC_SEQ_TAG_EN
    case (idx)
      2'd0:    byte_sel = seq_q;
      2'd1:    byte_sel = data_q[23:16];
      2'd2:    byte_sel = data_q[15:8];
      default: byte_sel = data_q[7:0];
    endcase
`else
    case (idx)
      2'd0:    byte_sel = data_q[23:16];
      2'd1:    byte_sel = data_q[15:8];
      default: byte_sel = data_q[7:0];
    endcase
`endif
  end

  // Write strobe follows fifo_full in the same cycle; rst suppresses it immediately
  assign fifo_wr_en   = (state == ST_WRITE) && !fifo_full && !rst;
  assign fifo_din     = (state == ST_WRITE) ? byte_sel : '0;
  assign writing_done = (state == ST_DONE);
  assign err          = err_q;
  assign busy         = (state != ST_IDLE);
  assign drop_cnt     = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_req_q  <= 1'b0;
      data_q    <= '0;
      idx       <= '0;
      stall_cnt <= '0;
      err_q     <= 1'b0;
      drop_q    <= '0;
`ifdef TDC_SEQ_TAG_EN
      seq_q     <= '0;
`endif
    end else begin
      wr_req_q <= wr_req;
      if (req_edge && (state != ST_IDLE) && (drop_q != 8'hFF))
        drop_q <= drop_q + 8'd1;
      case (state)
        ST_IDLE: begin
          err_q <= 1'b0;
          if (req_edge) begin
            data_q    <= tdc_data;
            idx       <= '0;
            stall_cnt <= '0;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!fifo_full) begin
            stall_cnt <= '0;
            idx       <= idx + IDX_W'(1);
            if (last_byte) begin
              state <= ST_DONE;
`ifdef TDC_SEQ_TAG_EN
              seq_q <= seq_q + 8'd1;
`endif
            end
          end else if (stall_limit) begin
            // Remaining bytes are discarded; the record ends as an error
            state <= ST_DONE;
            err_q <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
        end
        ST_DONE: begin
          err_q <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tdc_fifo_writer.md
TDC_FIFO_WRITER -- requirements
Module: tdc_fifo_writer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning consecutive fifo_full cycles tolerated in WRITE before abort (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wr_req  input  1  record request level from TDC source; held high until writing_done seen.
REQ-005 SHALL have port tdc_data  input  24  measurement word, valid in the cycle the wr_req rising edge is sampled.
REQ-006 SHALL have port fifo_full  input  1  downstream byte FIFO full.
REQ-007 SHALL have port fifo_din  output  8  byte to FIFO.
REQ-008 SHALL have port fifo_wr_en  output  1  FIFO write strobe; one byte per high cycle.
REQ-009 SHALL have port writing_done  output  1  one-cycle pulse when a record ends, completed or aborted.
REQ-010 SHALL have port err  output  1  high only with writing_done, when the record was aborted by timeout.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port drop_cnt  output  8  saturating count of ignored requests.

Function
REQ-013 SHALL detect a request as wr_req=1 while the registered previous wr_req=0; a level held high is never a new request.
REQ-014 SHALL implement states IDLE, WRITE and DONE.
REQ-015 SHALL, on a request in IDLE, latch tdc_data, clear the byte index and stall counter, and enter WRITE next cycle.
REQ-016 SHALL, in WRITE, drive fifo_wr_en = !fifo_full combinationally, with fifo_din = the byte at the current index, MSB byte first ([23:16], [15:8], [7:0]).
REQ-017 SHALL advance the byte index only on cycles where fifo_wr_en=1; after the last byte is written the next state SHALL be DONE.
REQ-018 SHALL give a latency of request edge at cycle 0 -> bytes at cycles 1, 2, 3 -> writing_done at cycle 4 when fifo_full stays low.
REQ-019 SHALL count consecutive fifo_full cycles in WRITE and reset that count on any write.
REQ-020 SHALL, when the count reaches TIMEOUT_CYCLES, enter DONE with err=1 and discard the unwritten bytes.
REQ-021 SHALL, in DONE, assert writing_done for exactly one cycle, then return to IDLE.
REQ-022 SHALL, on a request edge while busy=1 (including in DONE), ignore it and increment drop_cnt, saturating at 255.
REQ-023 SHALL hold fifo_wr_en=0 outside WRITE; fifo_din SHALL be 0 outside WRITE.

Reset
REQ-024 SHALL, on rst, force state IDLE, fifo_wr_en=0, fifo_din=0, writing_done=0, err=0, busy=0, drop_cnt=0, previous wr_req=0 and all counters=0.
REQ-025 SHALL, on rst mid-record, emit no further bytes and no writing_done; a wr_req still high after rst SHALL count as a new request.

Configuration
REQ-026 SHALL, with macro TDC_SEQ_TAG_EN defined, prepend an 8-bit sequence byte to each record (4 bytes: seq, [23:16], [15:8], [7:0]) and give writing_done at cycle 5.
REQ-027 SHALL increment the sequence byte once per completed, non-aborted record, wrap 255->0, and reset it to 0.
REQ-028 SHALL, without TDC_SEQ_TAG_EN, write records of 3 bytes and contain no sequence register.

Structure
REQ-029 SHALL take from shared package tdc_pkg: the state encoding, TDC_DATA_W=24, BYTE_W=8, and the RECORD_BYTES constant (3, or 4 with the tag).
REQ-030 SHALL contain no sub-module; edge detect, stall counter and byte mux are inline.

Verification
REQ-031 SHALL verify: wr_req rises with tdc_data=24'hA1B2C3 and fifo_full=0 -> bytes A1, B2, C3 on cycles 1-3, then writing_done at cycle 4 with err=0.
REQ-032 SHALL verify: fifo_full high for 5 cycles starting at the second byte -> exactly 3 writes, in order, and writing_done at cycle 9.
REQ-033 SHALL verify: TIMEOUT_CYCLES=4 and fifo_full held high after the first byte -> 1 write, writing_done with err=1, and busy low the next cycle.
REQ-034 SHALL verify: wr_req falls then rises during WRITE -> drop_cnt=1 and the record is unaffected; after 300 such requests, drop_cnt=255.
REQ-035 SHALL verify: rst asserted after the first byte while wr_req stays high -> no done pulse, then a new record of 3 bytes starts after rst releases.
REQ-036 SHALL verify: with TDC_SEQ_TAG_EN, 257 back-to-back records -> sequence bytes 00..FF, then 00.
